iic_mux_arb_3: RTL and testbench

Round-robin arbiter and sequencer for the 3-way IIC bus mux. Three local IIC masters request the single shared SDA/SCL pad pair. The block drives the mux select, grants exactly one master at a time, and monitors the shared bus for START/STOP. It only switches ownership when the bus is idle, and enforces a guard time and a hold timeout.

---
 rtl/iic_mux_arb_3.sv | 215 +++++++++++++++++++++
 tb/tb_iic_mux_arb_3.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_mux_arb_3.sv
// Round-robin arbiter/sequencer for a 3-way IIC pad mux.
// Grants one local master at a time and watches the shared pads for
// START/STOP. Ownership only changes once the bus has been idle for a
// guard period. A hold timeout and an idle-wait timeout recover from
// stuck masters.
module iic_mux_arb_3 #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int GUARD_CYCLES   = 100
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic [2:0] REQ_I,
    output logic [2:0] GNT_O,
    output logic [1:0] SEL_O,
    input  logic       SDA_I,
    input  logic       SCL_I,
    output logic       BUSY_O,
    output logic       TIMEOUT_O
);

    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SWITCH    = 2'd1,
        ST_OWNED     = 2'd2,
        ST_WAIT_IDLE = 2'd3
    } state_t;

    // Pad sampling: bit 0 = SDA, bit 1 = SCL
    logic [1:0] pad_meta_reg;
    logic [1:0] pad_sync_reg;
    logic [1:0] pad_hist_reg;

    state_t             state_reg, state_next;
    logic [1:0]         sel_reg, sel_next;
    logic [2:0]         gnt_reg, gnt_next;
    logic [1:0]         ptr_reg, ptr_next;
    logic [2:0]         mask_reg, mask_next, mask_set;
    logic [TMO_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [TMO_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [GUARD_W-1:0] guard_cnt_reg, guard_cnt_next;
    logic               busy_reg, busy_next;
    logic               timeout_reg, timeout_next;
    logic               force_idle;

    logic               start_det, stop_det;
    logic [2:0]         eligible;
    logic               pick_valid;
    logic [1:0]         pick_idx;
    logic [1:0]         cand1, cand2;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    function automatic logic [2:0] onehot3(input logic [1:0] v);
        return 3'(3'b001 << v);
    endfunction

    // Two-stage synchronizer plus one history stage; pads idle high
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            pad_meta_reg <= 2'b11;
            pad_sync_reg <= 2'b11;
            pad_hist_reg <= 2'b11;
        end else begin
            pad_meta_reg <= {SCL_I, SDA_I};
            pad_sync_reg <= pad_meta_reg;
            pad_hist_reg <= pad_sync_reg;
        end
    end

    // SDA edge while SCL is high in both the current and previous sample
    assign start_det = pad_hist_reg[0] & ~pad_sync_reg[0] & pad_hist_reg[1] & pad_sync_reg[1];
    assign stop_det  = ~pad_hist_reg[0] & pad_sync_reg[0] & pad_hist_reg[1] & pad_sync_reg[1];

    // Busy flag; the idle-wait timeout forcibly clears it
    always_comb begin
        busy_next = busy_reg;
        if (force_idle) begin
            busy_next = 1'b0;
        end else if (start_det && !stop_det) begin
            busy_next = 1'b1;
        end else if (stop_det && !start_det) begin
            busy_next = 1'b0;
        end
    end

    // A mask bit stays set until its master is seen with request low
    assign eligible = REQ_I & ~mask_reg;
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_mask
            assign mask_next[gi] = mask_set[gi] | (mask_reg[gi] & REQ_I[gi]);
        end
    endgenerate

    // Round-robin pick starting at ptr
    assign cand1 = inc3(ptr_reg);
    assign cand2 = inc3(cand1);
    always_comb begin
        pick_valid = 1'b1;
        pick_idx   = ptr_reg;
        if (eligible[ptr_reg]) begin
            pick_idx = ptr_reg;
        end else if (eligible[cand1]) begin
            pick_idx = cand1;
        end else if (eligible[cand2]) begin
            pick_idx = cand2;
        end else begin
            pick_valid = 1'b0;
        end
    end

    // Next-state and registered-output logic; SEL holds the owner index
    always_comb begin
        state_next     = state_reg;
        sel_next       = sel_reg;
        gnt_next       = gnt_reg;
        ptr_next       = ptr_reg;
        mask_set       = 3'b000;
        hold_cnt_next  = hold_cnt_reg;
        wait_cnt_next  = wait_cnt_reg;
        guard_cnt_next = guard_cnt_reg;
        timeout_next   = 1'b0;
        force_idle     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!busy_reg && pick_valid) begin
                    sel_next   = pick_idx;
                    state_next = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                ptr_next       = inc3(sel_reg);
                hold_cnt_next  = '0;
                wait_cnt_next  = '0;
                guard_cnt_next = '0;
                if (REQ_I[sel_reg]) begin
                    gnt_next   = onehot3(sel_reg);
                    state_next = ST_OWNED;
                end else begin
                    state_next = ST_WAIT_IDLE;
                end
            end
            ST_OWNED: begin
                hold_cnt_next  = hold_cnt_reg + TMO_W'(1);
                wait_cnt_next  = '0;
                guard_cnt_next = '0;
                if (!REQ_I[sel_reg]) begin
                    gnt_next   = 3'b000;
                    state_next = ST_WAIT_IDLE;
                end else if (hold_cnt_reg == TMO_LAST) begin
                    gnt_next     = 3'b000;
                    timeout_next = 1'b1;
                    mask_set     = onehot3(sel_reg);
                    state_next   = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                wait_cnt_next = wait_cnt_reg + TMO_W'(1);
                if (busy_reg) begin
                    guard_cnt_next = '0;
                end else if (guard_cnt_reg != GUARD_LAST) begin
                    guard_cnt_next = guard_cnt_reg + GUARD_W'(1);
                end
                if (!busy_reg && guard_cnt_reg == GUARD_LAST) begin
                    state_next = ST_IDLE;
                end else if (wait_cnt_reg == TMO_LAST) begin
                    // Master abandoned the bus mid-transfer: reclaim it
                    force_idle   = 1'b1;
                    timeout_next = 1'b1;
                    state_next   = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and control registers
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_reg     <= ST_IDLE;
            sel_reg       <= 2'd0;
            gnt_reg       <= 3'b000;
            ptr_reg       <= 2'd0;
            mask_reg      <= 3'b000;
            hold_cnt_reg  <= '0;
            wait_cnt_reg  <= '0;
            guard_cnt_reg <= '0;
            busy_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sel_reg       <= sel_next;
            gnt_reg       <= gnt_next;
            ptr_reg       <= ptr_next;
            mask_reg      <= mask_next;
            hold_cnt_reg  <= hold_cnt_next;
            wait_cnt_reg  <= wait_cnt_next;
            guard_cnt_reg <= guard_cnt_next;
            busy_reg      <= busy_next;
            timeout_reg   <= timeout_next;
        end
    end

    assign GNT_O     = gnt_reg;
    assign SEL_O     = sel_reg;
    assign BUSY_O    = busy_reg;
    assign TIMEOUT_O = timeout_reg;

endmodule

// File: tb/tb_iic_mux_arb_3.sv
// Bench for iic_mux_arb_3: table-driven round-robin vectors, hand-written
// bus-busy / timeout / reset sequences, and a grant scoreboard.
module tb_iic_mux_arb_3;

    localparam int TMO   = 50;
    localparam int GUARD = 4;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b1;
    logic [2:0] REQ_I = 3'b000;
    logic       SDA_I = 1'b1;
    logic       SCL_I = 1'b1;
    logic [2:0] GNT_O;
    logic [1:0] SEL_O;
    logic       BUSY_O;
    logic       TIMEOUT_O;

    int total = 0;
    int bad   = 0;

    int unsigned sb_q[$];
    int unsigned exp_m;
    logic [2:0]  gnt_prev = 3'b000;

    typedef struct {
        logic [2:0] req;
        logic [1:0] exp_sel;
        logic [2:0] exp_gnt;
    } vec_t;
    vec_t vecs[7];

    iic_mux_arb_3 #(
        .TIMEOUT_CYCLES(TMO),
        .GUARD_CYCLES  (GUARD)
    ) dut (
        .CLK_I    (CLK_I),
        .RST_I    (RST_I),
        .REQ_I    (REQ_I),
        .GNT_O    (GNT_O),
        .SEL_O    (SEL_O),
        .SDA_I    (SDA_I),
        .SCL_I    (SCL_I),
        .BUSY_O   (BUSY_O),
        .TIMEOUT_O(TIMEOUT_O)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic wait_busy(input logic val, input int limit);
        int n = 0;
        while (BUSY_O !== val && n < limit) begin
            tick();
            n++;
        end
        check("busy_wait", {31'b0, BUSY_O}, {31'b0, val});
    endtask

    task automatic release_all();
        REQ_I = 3'b000;
        tick();
        check("release_gnt", {29'b0, GNT_O}, 32'h0);
        repeat (GUARD) tick();
    endtask

    // Per-cycle invariants and grant scoreboard
    always @(posedge CLK_I) begin
        #1;
        check("onehot", {31'b0, ($countones(GNT_O) <= 1)}, 32'h1);
        check("sel_range", {31'b0, (SEL_O != 2'd3)}, 32'h1);
        if (gnt_prev == 3'b000 && GNT_O != 3'b000) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got gnt %b want no grant at %0t", GNT_O, $time);
            end else begin
                exp_m = sb_q.pop_front();
                check("sb_gnt", {29'b0, GNT_O}, 32'(1 << exp_m));
                check("sb_sel", {30'b0, SEL_O}, exp_m);
                $display("grant: master %0d gnt=%b sel=%0d t=%0t", exp_m, GNT_O, SEL_O, $time);
            end
        end
        gnt_prev = GNT_O;
    end

    initial begin
        vecs[0] = '{req: 3'b001, exp_sel: 2'd0, exp_gnt: 3'b001};
        vecs[1] = '{req: 3'b111, exp_sel: 2'd1, exp_gnt: 3'b010};
        vecs[2] = '{req: 3'b111, exp_sel: 2'd2, exp_gnt: 3'b100};
        vecs[3] = '{req: 3'b111, exp_sel: 2'd0, exp_gnt: 3'b001};
        vecs[4] = '{req: 3'b101, exp_sel: 2'd2, exp_gnt: 3'b100};
        vecs[5] = '{req: 3'b110, exp_sel: 2'd1, exp_gnt: 3'b010};
        vecs[6] = '{req: 3'b011, exp_sel: 2'd0, exp_gnt: 3'b001};

        // Reset state
        repeat (3) tick();
        check("rst_sel", {30'b0, SEL_O}, 32'h0);
        check("rst_gnt", {29'b0, GNT_O}, 32'h0);
        check("rst_busy", {31'b0, BUSY_O}, 32'h0);
        check("rst_tmo", {31'b0, TIMEOUT_O}, 32'h0);
        RST_I = 1'b0;

        // Round-robin vectors: grant, hold 10 cycles, drop, re-request
        for (int i = 0; i < 7; i++) begin
            REQ_I = vecs[i].req;
            sb_q.push_back(int'(vecs[i].exp_sel));
            if (i > 0) begin
                for (int g = 0; g < GUARD; g++) begin
                    tick();
                    check("guard_gnt", {29'b0, GNT_O}, 32'h0);
                    check("guard_sel", {30'b0, SEL_O}, {30'b0, vecs[i-1].exp_sel});
                end
            end
            tick();
            check("vec_sel", {30'b0, SEL_O}, {30'b0, vecs[i].exp_sel});
            tick();
            check("vec_gnt", {29'b0, GNT_O}, {29'b0, vecs[i].exp_gnt});
            check("vec_busy", {31'b0, BUSY_O}, 32'h0);
            for (int h = 0; h < 10; h++) begin
                tick();
                check("vec_hold", {29'b0, GNT_O}, {29'b0, vecs[i].exp_gnt});
            end
            REQ_I = 3'b000;
            tick();
            check("vec_release", {29'b0, GNT_O}, 32'h0);
        end
        repeat (GUARD) tick();

        // Master 1 releases mid-transfer; master 2 waits for STOP + guard
        REQ_I = 3'b010;
        sb_q.push_back(1);
        tick();
        check("busy_sel1", {30'b0, SEL_O}, 32'h1);
        tick();
        check("busy_gnt1", {29'b0, GNT_O}, 32'h2);
        REQ_I = 3'b110;
        SDA_I = 1'b0;
        wait_busy(1'b1, 10);
        REQ_I = 3'b100;
        sb_q.push_back(2);
        tick();
        check("busy_drop", {29'b0, GNT_O}, 32'h0);
        for (int c = 0; c < 20; c++) begin
            tick();
            check("busy_hold_sel", {30'b0, SEL_O}, 32'h1);
            check("busy_hold_flag", {31'b0, BUSY_O}, 32'h1);
        end
        SDA_I = 1'b1;
        wait_busy(1'b0, 10);
        for (int g = 0; g < GUARD; g++) begin
            tick();
            check("busy_guard_sel", {30'b0, SEL_O}, 32'h1);
            check("busy_guard_gnt", {29'b0, GNT_O}, 32'h0);
        end
        tick();
        check("busy_sel2", {30'b0, SEL_O}, 32'h2);
        tick();
        check("busy_gnt2", {29'b0, GNT_O}, 32'h4);
        release_all();

        // Hold timeout on master 0, then masked until it re-requests
        REQ_I = 3'b001;
        sb_q.push_back(0);
        tick();
        check("hold_sel", {30'b0, SEL_O}, 32'h0);
        tick();
        check("hold_gnt", {29'b0, GNT_O}, 32'h1);
        for (int c = 0; c < TMO - 1; c++) begin
            tick();
            check("hold_keep", {29'b0, GNT_O}, 32'h1);
            check("hold_no_tmo", {31'b0, TIMEOUT_O}, 32'h0);
        end
        tick();
        check("hold_tmo_gnt", {29'b0, GNT_O}, 32'h0);
        check("hold_tmo_pulse", {31'b0, TIMEOUT_O}, 32'h1);
        tick();
        check("hold_tmo_end", {31'b0, TIMEOUT_O}, 32'h0);
        for (int c = 0; c < 15; c++) begin
            tick();
            check("hold_masked", {29'b0, GNT_O}, 32'h0);
        end
        REQ_I = 3'b000;
        tick();
        REQ_I = 3'b001;
        sb_q.push_back(0);
        tick();
        check("hold_resel", {30'b0, SEL_O}, 32'h0);
        tick();
        check("hold_regnt", {29'b0, GNT_O}, 32'h1);
        release_all();

        // Bus stuck busy in WAIT_IDLE: idle-wait timeout recovers it
        REQ_I = 3'b100;
        sb_q.push_back(2);
        tick();
        check("stuck_sel2", {30'b0, SEL_O}, 32'h2);
        tick();
        check("stuck_gnt2", {29'b0, GNT_O}, 32'h4);
        REQ_I = 3'b110;
        SDA_I = 1'b0;
        wait_busy(1'b1, 10);
        REQ_I = 3'b010;
        sb_q.push_back(1);
        tick();
        check("stuck_drop", {29'b0, GNT_O}, 32'h0);
        for (int c = 0; c < TMO - 1; c++) begin
            tick();
            check("stuck_no_tmo", {31'b0, TIMEOUT_O}, 32'h0);
            check("stuck_no_gnt", {29'b0, GNT_O}, 32'h0);
        end
        tick();
        check("stuck_tmo", {31'b0, TIMEOUT_O}, 32'h1);
        check("stuck_busy_clr", {31'b0, BUSY_O}, 32'h0);
        tick();
        check("stuck_tmo_end", {31'b0, TIMEOUT_O}, 32'h0);
        check("stuck_sel1", {30'b0, SEL_O}, 32'h1);
        tick();
        check("stuck_gnt1", {29'b0, GNT_O}, 32'h2);

        // Reset while master 1 owns a busy bus
        SDA_I = 1'b1;
        repeat (5) tick();
        SDA_I = 1'b0;
        wait_busy(1'b1, 10);
        RST_I = 1'b1;
        SDA_I = 1'b1;
        tick();
        check("mid_rst_gnt", {29'b0, GNT_O}, 32'h0);
        check("mid_rst_sel", {30'b0, SEL_O}, 32'h0);
        check("mid_rst_busy", {31'b0, BUSY_O}, 32'h0);
        check("mid_rst_tmo", {31'b0, TIMEOUT_O}, 32'h0);
        RST_I = 1'b0;
        sb_q.push_back(1);
        tick();
        check("post_rst_sel", {30'b0, SEL_O}, 32'h1);
        check("post_rst_busy", {31'b0, BUSY_O}, 32'h0);
        tick();
        check("post_rst_gnt", {29'b0, GNT_O}, 32'h2);
        release_all();

        check("sb_drain", sb_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
